arcade_coin_start_seq: RTL and testbench

- Upstream input conditioner between the keyboard/joystick merge logic and dkongjr_top's active-high button nets (top inverts to active-low I_C1/I_S1/I_S2).
- Replaces the combinational "coin = start1|start2" hack with a timed sequence: one start press produces a coin pulse, a gap, then the matching start pulse, so the game CPU reliably sees credit then start.
- Also debounces the raw coin/start sources and passes manual coin inputs through.

---
 rtl/arcade_input_pkg.sv | 19 +
 rtl/arcade_coin_start_seq_if.sv | 25 ++
 rtl/arcade_coin_start_seq_debounce.sv | 44 ++++
 rtl/arcade_coin_start_seq.sv | 129 ++++++++++++
 tb/tb_arcade_coin_start_seq.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arcade_input_pkg.sv
// Shared types and default timing for the arcade coin/start input conditioner.
// Cycle defaults assume a 24.576 MHz clk_sys.
package arcade_input_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COIN  = 3'd1,
    GAP   = 3'd2,
    START = 3'd3,
    HOLD  = 3'd4
  } seq_state_t;

  localparam int DEF_DEB_CYCLES   = 122880;   // 5 ms
  localparam int DEF_COIN_CYCLES  = 2457600;  // 100 ms
  localparam int DEF_GAP_CYCLES   = 4915200;  // 200 ms
  localparam int DEF_START_CYCLES = 2457600;  // 100 ms
  localparam int DEF_CNT_W        = 23;

endpackage

// File: rtl/arcade_coin_start_seq_if.sv
// Raw button inputs, mode select and conditioned outputs of the coin/start sequencer.
// master drives the raw side, slave is the conditioner itself.
interface arcade_coin_start_seq_if;

  logic start1_in;
  logic start2_in;
  logic coin1_in;
  logic coin2_in;
  logic auto_coin;
  logic coin_out;
  logic start1_out;
  logic start2_out;
  logic busy;

  modport master (
    output start1_in, start2_in, coin1_in, coin2_in, auto_coin,
    input  coin_out, start1_out, start2_out, busy
  );

  modport slave (
    input  start1_in, start2_in, coin1_in, coin2_in, auto_coin,
    output coin_out, start1_out, start2_out, busy
  );

endinterface

// File: rtl/arcade_coin_start_seq_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer; the output
// flips only after DEB_CYCLES consecutive cycles of disagreement.
module input_debounce #(
  parameter int DEB_CYCLES = 122880
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          meta;
  logic          sync;
  logic [DW-1:0] cnt;

  // Synchroniser for the asynchronous raw input
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  // Any agreement restarts the stability count
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt  <= {DW{1'b0}};
      dout <= 1'b0;
    end else if (sync == dout) begin
      cnt  <= {DW{1'b0}};
    end else if (cnt == DW'(DEB_CYCLES - 1)) begin
      cnt  <= {DW{1'b0}};
      dout <= sync;
    end else begin
      cnt  <= cnt + DW'(1);
    end
  end

endmodule

// File: rtl/arcade_coin_start_seq.sv
// Coin/start input conditioner: debounces raw buttons and turns one start press
// into a timed coin pulse, gap and matching start pulse for the game CPU.
module arcade_coin_start_seq
  import arcade_input_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int COIN_CYCLES  = DEF_COIN_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int START_CYCLES = DEF_START_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic                    clk_sys,
  input logic                    reset,
  arcade_coin_start_seq_if.slave io
);

  logic start1_db, start2_db, coin1_db, coin2_db;
  logic start1_prev, start2_prev;
  logic start1_edge, start2_edge;

  seq_state_t       state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             sel, next_sel;  // 0 = start1, 1 = start2
  logic             auto_coin_pulse, auto_start1_pulse, auto_start2_pulse;

  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start1 (
    .clk_sys(clk_sys), .reset(reset), .din(io.start1_in), .dout(start1_db));
  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start2 (
    .clk_sys(clk_sys), .reset(reset), .din(io.start2_in), .dout(start2_db));
  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_coin1 (
    .clk_sys(clk_sys), .reset(reset), .din(io.coin1_in), .dout(coin1_db));
  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_coin2 (
    .clk_sys(clk_sys), .reset(reset), .din(io.coin2_in), .dout(coin2_db));

  assign start1_edge = start1_db & ~start1_prev;
  assign start2_edge = start2_db & ~start2_prev;

  // Sequencer registers and previous debounced start levels
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= {CNT_W{1'b0}};
      sel         <= 1'b0;
      start1_prev <= 1'b0;
      start2_prev <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      sel         <= next_sel;
      start1_prev <= start1_db;
      start2_prev <= start2_db;
    end
  end

  // Next-state logic; one down-counter reloaded with N-1 on each phase entry
  always_comb begin
    next_state        = state;
    next_cnt          = cnt;
    next_sel          = sel;
    auto_coin_pulse   = 1'b0;
    auto_start1_pulse = 1'b0;
    auto_start2_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (io.auto_coin && (start1_edge || start2_edge)) begin
          next_sel   = ~start1_edge;
          next_cnt   = CNT_W'(COIN_CYCLES - 1);
          next_state = COIN;
        end else begin
          next_state = IDLE;
        end
      end
      COIN: begin
        auto_coin_pulse = 1'b1;
        if (cnt == {CNT_W{1'b0}}) begin
          next_cnt   = CNT_W'(GAP_CYCLES - 1);
          next_state = GAP;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == {CNT_W{1'b0}}) begin
          next_cnt   = CNT_W'(START_CYCLES - 1);
          next_state = START;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      START: begin
        auto_start1_pulse = ~sel;
        auto_start2_pulse = sel;
        if (cnt == {CNT_W{1'b0}}) begin
          next_state = HOLD;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        // Wait for key release so a held key cannot retrigger
        if (!start1_db && !start2_db) begin
          next_state = IDLE;
        end else begin
          next_state = HOLD;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Registered outputs to the core
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      io.coin_out   <= 1'b0;
      io.start1_out <= 1'b0;
      io.start2_out <= 1'b0;
      io.busy       <= 1'b0;
    end else begin
      io.coin_out   <= auto_coin_pulse | coin1_db | coin2_db;
      io.start1_out <= auto_start1_pulse | (~io.auto_coin & start1_db);
      io.start2_out <= auto_start2_pulse | (~io.auto_coin & start2_db);
      io.busy       <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_arcade_coin_start_seq.sv
// Bench for arcade_coin_start_seq with short timing; every cycle is compared
// against a timeline-based reference model of the debounce and coin/start sequence.
module tb_arcade_coin_start_seq;

  localparam int DEB  = 4;
  localparam int CC   = 8;
  localparam int GC   = 6;
  localparam int SC   = 8;
  localparam int MAXC = 8192;

  logic clk_sys = 1'b0;
  logic reset;
  arcade_coin_start_seq_if io ();

  arcade_coin_start_seq #(
    .DEB_CYCLES(DEB), .COIN_CYCLES(CC), .GAP_CYCLES(GC), .START_CYCLES(SC), .CNT_W(23)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .io     (io)
  );

  always #5 clk_sys = ~clk_sys;

  wire [3:0] dut_v = {io.coin_out, io.start1_out, io.start2_out, io.busy};

  // channel 0 = start1, 1 = start2, 2 = coin1, 3 = coin2
  bit   raw_h  [4][MAXC];
  bit   sync_h [4][MAXC];
  bit   db_h   [4][MAXC];
  int   last_flip [4];
  int   last_reset = 0;
  int   cyc = 0;
  int   t0 = -1;          // cycle at which the current sequence entered its coin phase
  int   sel_m = 1;
  logic [3:0] exp_v = 4'b0000;
  int   checks = 0;
  int   errors = 0;

  // 0 idle, 1 coin, 2 gap, 3 start, 4 hold -- as a function of elapsed time
  function automatic int phase_at(int m);
    int el;
    if (t0 < 0) return 0;
    el = m - t0;
    if (el < CC) return 1;
    if (el < CC + GC) return 2;
    if (el < CC + GC + SC) return 3;
    return 4;
  endfunction

  task automatic model_update();
    int n;
    int p;
    bit raw_now [4];
    bit e1, e2, d, all_diff;
    n = cyc;
    raw_now[0] = io.start1_in; raw_now[1] = io.start2_in;
    raw_now[2] = io.coin1_in;  raw_now[3] = io.coin2_in;
    if (reset) begin
      last_reset = n;
      for (int i = 0; i < 4; i++) begin
        raw_h[i][n] = raw_now[i]; sync_h[i][n] = 1'b0; db_h[i][n] = 1'b0; last_flip[i] = n;
      end
      t0 = -1;
      exp_v = 4'b0000;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      raw_h[i][n]  = raw_now[i];
      sync_h[i][n] = (n - 1 > last_reset) ? raw_h[i][n-1] : 1'b0;
      d = db_h[i][n-1];
      if (n - last_flip[i] >= DEB) begin
        all_diff = 1'b1;
        for (int k = n - DEB; k < n; k++) if (sync_h[i][k] == d) all_diff = 1'b0;
        if (all_diff) begin d = ~d; last_flip[i] = n; end
      end
      db_h[i][n] = d;
    end
    p = phase_at(n - 1);
    exp_v[3] = (p == 1) | db_h[2][n-1] | db_h[3][n-1];
    exp_v[2] = (p == 3 && sel_m == 1) | (!io.auto_coin && db_h[0][n-1]);
    exp_v[1] = (p == 3 && sel_m == 2) | (!io.auto_coin && db_h[1][n-1]);
    exp_v[0] = (p != 0);
    e1 = (n - 1 > last_reset) ? (db_h[0][n-1] & ~db_h[0][n-2]) : 1'b0;
    e2 = (n - 1 > last_reset) ? (db_h[1][n-1] & ~db_h[1][n-2]) : 1'b0;
    if (p == 0 && io.auto_coin && (e1 || e2)) begin
      t0 = n;
      sel_m = e1 ? 1 : 2;
    end else if (p == 4 && !db_h[0][n-1] && !db_h[1][n-1]) begin
      t0 = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    model_update();
  endtask

  task automatic set_inputs(bit s1, bit s2, bit c1, bit c2);
    io.start1_in = s1; io.start2_in = s2; io.coin1_in = c1; io.coin2_in = c2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (dut_v !== 4'b0000) begin
        errors++; $display("FAIL reset_outputs got=%b exp=0000", dut_v);
      end
    end
    reset = 1'b0;
    repeat (5) begin
      tick();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_sequence();
    int first_coin = -1, first_s1 = -1, ncoin = 0, ns1 = 0, ns2 = 0;
    io.auto_coin = 1'b1;
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= 60; t++) begin
      if (t == 41) io.start1_in = 1'b0;
      tick();
      if (io.coin_out) begin ncoin++; if (first_coin < 0) first_coin = t; end
      if (io.start1_out) begin ns1++; if (first_s1 < 0) first_s1 = t; end
      if (io.start2_out) ns2++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL seq_model cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (first_coin != 2 + DEB + 2) begin errors++; $display("FAIL seq_coin_latency got=%0d exp=%0d", first_coin, 2 + DEB + 2); end
    checks++;
    if (ncoin != CC) begin errors++; $display("FAIL seq_coin_len got=%0d exp=%0d", ncoin, CC); end
    checks++;
    if (first_s1 != 2 + DEB + 2 + CC + GC) begin errors++; $display("FAIL seq_gap got=%0d exp=%0d", first_s1, 2 + DEB + 2 + CC + GC); end
    checks++;
    if (ns1 != SC || ns2 != 0) begin errors++; $display("FAIL seq_start_len s1=%0d s2=%0d exp=%0d,0", ns1, ns2, SC); end
    checks++;
    if (io.busy !== 1'b0) begin errors++; $display("FAIL seq_busy_end got=%b exp=0", io.busy); end
  endtask

  task automatic test_bounce();
    int active = 0;
    for (int t = 0; t < 50; t++) begin
      io.start1_in = (t < 30) ? ((t / 2) % 2 == 0) : 1'b0;
      tick();
      if (dut_v !== 4'b0000) active++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (active != 0) begin errors++; $display("FAIL bounce_quiet active=%0d exp=0", active); end
  endtask

  task automatic test_both();
    int ns1 = 0, ns2 = 0;
    set_inputs(1'b1, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 70; t++) begin
      if (t == 41) set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      if (io.start1_out) ns1++;
      if (io.start2_out) ns2++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL both_model cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (ns1 != SC || ns2 != 0) begin errors++; $display("FAIL both_sel s1=%0d s2=%0d exp=%0d,0", ns1, ns2, SC); end
  endtask

  task automatic test_gap_ignore();
    int ncoin = 0, ns2 = 0;
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= 80; t++) begin
      if (t == 13) io.start1_in = 1'b0;
      if (t == 17) io.start2_in = 1'b1;   // state is GAP from here
      if (t == 37) io.start2_in = 1'b0;
      tick();
      if (io.coin_out) ncoin++;
      if (io.start2_out) ns2++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL gap_model cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (ncoin != CC || ns2 != 0) begin errors++; $display("FAIL gap_no_retrigger coin=%0d s2=%0d exp=%0d,0", ncoin, ns2, CC); end
  endtask

  task automatic test_passthrough();
    int first_s2 = -1, ns2 = 0, ncoin = 0, nbusy = 0, first_coin = -1;
    io.auto_coin = 1'b0;
    io.start2_in = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      if (t == 21) io.start2_in = 1'b0;
      tick();
      if (io.start2_out) begin ns2++; if (first_s2 < 0) first_s2 = t; end
      if (io.coin_out) ncoin++;
      if (io.busy) nbusy++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL pass_model cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (first_s2 != 2 + DEB + 1 || ns2 != 20) begin errors++; $display("FAIL pass_start2 first=%0d n=%0d exp=%0d,20", first_s2, ns2, 2 + DEB + 1); end
    checks++;
    if (ncoin != 0 || nbusy != 0) begin errors++; $display("FAIL pass_quiet coin=%0d busy=%0d exp=0,0", ncoin, nbusy); end
    ncoin = 0;
    io.coin1_in = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      if (t == 11) io.coin1_in = 1'b0;
      tick();
      if (io.coin_out) begin ncoin++; if (first_coin < 0) first_coin = t; end
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL coin_model cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (first_coin != 2 + DEB + 1 || ncoin != 10) begin errors++; $display("FAIL manual_coin first=%0d n=%0d exp=%0d,10", first_coin, ncoin, 2 + DEB + 1); end
    io.auto_coin = 1'b1;
  endtask

  task automatic test_reset_mid();
    int ncoin = 0;
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    checks++;
    if (io.coin_out !== 1'b1) begin errors++; $display("FAIL mid_in_coin got=%b exp=1", io.coin_out); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (io.coin_out !== 1'b0 || io.busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset coin=%b busy=%b exp=0,0", io.coin_out, io.busy);
    end
    for (int t = 1; t <= 60; t++) begin
      if (t == 45) io.start1_in = 1'b0;
      tick();
      if (io.coin_out) ncoin++;
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL mid_model cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
      end
    end
    checks++;
    if (ncoin != CC) begin errors++; $display("FAIL mid_rerun coin=%0d exp=%0d", ncoin, CC); end
  endtask

  task automatic test_random();
    int dur;
    bit [3:0] r;
    for (int seg = 0; seg < 30; seg++) begin
      r = 4'($urandom);
      set_inputs(r[0], r[1], ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      io.auto_coin = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 19) == 0);
      dur = $urandom_range(1, 40);
      for (int t = 0; t < dur; t++) begin
        tick();
        reset = 1'b0;
        checks++;
        if (dut_v !== exp_v) begin
          errors++; $display("FAIL rand_model cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
        end
      end
    end
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
    io.auto_coin = 1'b1;
    repeat (60) begin
      tick();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL rand_drain cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    io.auto_coin = 1'b1;
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) last_flip[i] = 0;
    test_reset();
    test_sequence();
    test_bounce();
    test_both();
    test_gap_ignore();
    test_passthrough();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
